// File: rtl/kernel_bc_start_token_sink.sv
// Consumer end of a dataflow start-token FIFO. Pops tokens, launches the
// downstream task through ap_start/ap_ready, tracks in-flight invocations,
// gates ap_continue, counts completions and flags stray ap_done pulses.
module kernel_bc_start_token_sink #(
  parameter int unsigned DATA_WIDTH   = 1,
  parameter int unsigned MAX_INFLIGHT = 2,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   enable,
  input  logic                                   fifo_empty_n,
  input  logic [DATA_WIDTH-1:0]                  fifo_dout,
  output logic                                   fifo_read,
  output logic                                   task_start,
  input  logic                                   task_ready,
  input  logic                                   task_done,
  output logic                                   task_continue,
  output logic [DATA_WIDTH-1:0]                  tok_data,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]      inflight,
  output logic [CNT_WIDTH-1:0]                   done_cnt,
  output logic                                   busy,
  output logic                                   err_sticky
);

  localparam int unsigned IW  = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned IW1 = IW + 1;

  typedef enum logic {S_IDLE, S_START} state_t;

  state_t         state;
  state_t         state_nxt;
  logic           launch_hs;
  logic           done_hs;
  logic           pop;
  logic [IW1-1:0] inflight_nxt;

  // Handshakes and the occupancy the pop decision is made against
  always_comb begin
    launch_hs     = 1'b0;
    done_hs       = 1'b0;
    inflight_nxt  = '0;
    pop           = 1'b0;
    task_start    = (state == S_START) && !reset;
    task_continue = (inflight != '0) && !reset;
    busy          = !reset && ((state != S_IDLE) || (inflight != '0));
    launch_hs     = task_start && task_ready;
    done_hs       = task_done && task_continue;
    // done_hs requires inflight != 0, so this never underflows
    inflight_nxt  = {1'b0, inflight} + IW1'(launch_hs) - IW1'(done_hs);
    pop           = !reset && enable && fifo_empty_n &&
                    (inflight_nxt < IW1'(MAX_INFLIGHT));
  end

  // Next-state and pop strobe; an open start holds until accepted
  always_comb begin
    state_nxt = state;
    fifo_read = 1'b0;
    case (state)
      S_IDLE: begin
        if (pop) begin
          fifo_read = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (task_ready) begin
          if (pop) begin
            fifo_read = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, token capture, occupancy, completion count and error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      tok_data   <= '0;
      inflight   <= '0;
      done_cnt   <= '0;
      err_sticky <= 1'b0;
    end else begin
      state <= state_nxt;
      if (fifo_read) begin
        tok_data <= fifo_dout;
      end
      inflight <= IW'(inflight_nxt);
      done_cnt <= done_cnt + CNT_WIDTH'(done_hs);
      if (task_done && (inflight == '0) && !launch_hs) begin
        err_sticky <= 1'b1;
      end
    end
  end

endmodule
